sr_config_tx: RTL and testbench

- Configuration transmitter for the pulse-divider serial configuration interface. It drives sr_data, sr_clk, sr_sel_div, sr_sel_row and sr_reset.
- The host control logic hands it a 16-bit word plus a target select. The block serialises the word MSB-first into the divider or row-length shift register, then reports completion.
- It also issues standalone shift-register clear pulses.
- Sits on the controller side of the serial link, clocked from the system clock. sr_clk is derived internally, not a free-running clock.

---
 rtl/sr_config_tx.sv | 183 ++++++++++++++++++
 tb/tb_sr_config_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_config_tx.sv
// Serial configuration transmitter: shifts a captured word MSB-first into the divider or
// row shift register through a generated sr_clk, and issues standalone sr_reset pulses.
// Optional build macro SR_AUTOCLEAR_EN: precede every load with a clear phase.
module sr_config_tx #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic             cfg_clk,
  input  logic             cfg_reset_n,
  input  logic             start,
  input  logic             target_sel,
  input  logic [WIDTH-1:0] load_data,
  input  logic             clear_req,
  output logic             busy,
  output logic             done,
  output logic             sr_data,
  output logic             sr_clk,
  output logic             sr_sel_div,
  output logic             sr_sel_row,
  output logic             sr_reset
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [7:0]    PH_LAST = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_TOP = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_HOLD = 3'd3,
    S_CLR  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t           state_q;
  logic [7:0]       phase_q;
  logic [BW-1:0]    bit_q;
  logic [WIDTH-1:0] data_q;
  logic             tgt_q;
  logic             pend_q;
  logic             busy_q;
  logic             done_q;
  logic             sr_data_q;
  logic             sr_clk_q;
  logic             sel_div_q;
  logic             sel_row_q;
  logic             sr_reset_q;

  logic             ph_last_s;
  logic [BW-1:0]    bit_dec_s;

  assign ph_last_s = (phase_q == PH_LAST);
  assign bit_dec_s = bit_q - BW'(1);

  assign busy       = busy_q;
  assign done       = done_q;
  assign sr_data    = sr_data_q;
  assign sr_clk     = sr_clk_q;
  assign sr_sel_div = sel_div_q;
  assign sr_sel_row = sel_row_q;
  assign sr_reset   = sr_reset_q;

  // Control FSM; every output is set on the transition into the state that owns it.
  always_ff @(posedge cfg_clk) begin
    if (!cfg_reset_n) begin
      state_q    <= S_IDLE;
      phase_q    <= 8'd0;
      bit_q      <= '0;
      data_q     <= '0;
      tgt_q      <= 1'b0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sr_data_q  <= 1'b0;
      sr_clk_q   <= 1'b0;
      sel_div_q  <= 1'b0;
      sel_row_q  <= 1'b0;
      sr_reset_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          phase_q <= 8'd0;
          if (clear_req) begin
            // A simultaneous start is dropped, not queued.
            state_q    <= S_CLR;
            busy_q     <= 1'b1;
            sr_reset_q <= 1'b1;
            pend_q     <= 1'b0;
          end else if (start) begin
            data_q <= load_data;
            tgt_q  <= target_sel;
            bit_q  <= BIT_TOP;
            busy_q <= 1'b1;
`ifdef SR_AUTOCLEAR_EN
            state_q    <= S_CLR;
            sr_reset_q <= 1'b1;
            pend_q     <= 1'b1;
`else
            state_q   <= S_LO;
            sr_data_q <= load_data[WIDTH-1];
            sel_div_q <= ~target_sel;
            sel_row_q <= target_sel;
`endif
          end
        end
        S_LO: begin
          if (ph_last_s) begin
            phase_q  <= 8'd0;
            sr_clk_q <= 1'b1;
            state_q  <= S_HI;
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end
        S_HI: begin
          if (ph_last_s) begin
            phase_q  <= 8'd0;
            sr_clk_q <= 1'b0;
            if (bit_q == '0) begin
              state_q <= S_HOLD;
            end else begin
              bit_q     <= bit_dec_s;
              sr_data_q <= data_q[bit_dec_s];
              state_q   <= S_LO;
            end
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end
        S_HOLD: begin
          if (ph_last_s) begin
            phase_q   <= 8'd0;
            state_q   <= S_FIN;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            sr_data_q <= 1'b0;
            sel_div_q <= 1'b0;
            sel_row_q <= 1'b0;
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end
        S_CLR: begin
          if (ph_last_s) begin
            phase_q    <= 8'd0;
            sr_reset_q <= 1'b0;
            pend_q     <= 1'b0;
            // A pending load (auto-clear) goes straight to its first bit without FIN.
            if (pend_q) begin
              state_q   <= S_LO;
              sr_data_q <= data_q[BIT_TOP];
              sel_div_q <= ~tgt_q;
              sel_row_q <= tgt_q;
            end else begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          phase_q    <= 8'd0;
          busy_q     <= 1'b0;
          sr_data_q  <= 1'b0;
          sr_clk_q   <= 1'b0;
          sel_div_q  <= 1'b0;
          sel_row_q  <= 1'b0;
          sr_reset_q <= 1'b0;
          pend_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_config_tx.sv
// Self-checking bench for sr_config_tx: randomized loads and clears compared against a
// word/latency model derived from the transfer rules.
module tb_sr_config_tx;

  localparam int W = 16;
  localparam int D = 2;
`ifdef SR_AUTOCLEAR_EN
  localparam int AC = 1;
`else
  localparam int AC = 0;
`endif
  // Load cost: optional clear, D low + D high per bit, then D hold; FIN follows.
  localparam int LAT = AC * D + 2 * W * D + D;

  logic         cfg_clk;
  logic         cfg_reset_n;
  logic         start;
  logic         target_sel;
  logic [W-1:0] load_data;
  logic         clear_req;
  logic         busy, done, sr_data, sr_clk, sr_sel_div, sr_sel_row, sr_reset;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Observation state, filled by the monitor
  int         rise_cnt, busy_cnt, rst_cnt, done_cnt, done_cyc, first_busy;
  int         sel_err, stab_err, idle_err;
  logic [W-1:0] got_word;
  logic       prev_clk, prev_data, exp_tgt;

  sr_config_tx #(.WIDTH(W), .CLK_DIV(D)) dut (
    .cfg_clk    (cfg_clk),
    .cfg_reset_n(cfg_reset_n),
    .start      (start),
    .target_sel (target_sel),
    .load_data  (load_data),
    .clear_req  (clear_req),
    .busy       (busy),
    .done       (done),
    .sr_data    (sr_data),
    .sr_clk     (sr_clk),
    .sr_sel_div (sr_sel_div),
    .sr_sel_row (sr_sel_row),
    .sr_reset   (sr_reset)
  );

  initial cfg_clk = 1'b0;
  always #5 cfg_clk = ~cfg_clk;

  always @(posedge cfg_clk) cyc++;

  // Monitor: samples on the falling edge, recording what the target register would see.
  always @(negedge cfg_clk) begin
    if (sr_clk && !prev_clk) begin
      rise_cnt++;
      got_word = {got_word[W-2:0], sr_data};
      if (sr_data !== prev_data) stab_err++;
    end
    if (busy) begin
      busy_cnt++;
      if (first_busy < 0) first_busy = cyc;
      if (!sr_reset && (sr_sel_div !== !exp_tgt || sr_sel_row !== exp_tgt)) sel_err++;
      if (sr_reset && (sr_sel_div || sr_sel_row || sr_clk)) sel_err++;
    end else if (sr_sel_div || sr_sel_row || sr_reset || sr_clk || sr_data) begin
      idle_err++;
    end
    if (sr_reset) rst_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) idle_err++;
    end
    prev_clk  = sr_clk;
    prev_data = sr_data;
  end

  task automatic clear_stats;
    rise_cnt = 0; busy_cnt = 0; rst_cnt = 0; done_cnt = 0; done_cyc = -1;
    first_busy = -1; sel_err = 0; stab_err = 0; idle_err = 0; got_word = '0;
  endtask

  // Caller is aligned 1 time unit after a rising edge; returns aligned the same way.
  task automatic issue_start(input logic [W-1:0] d, input logic t, output int k);
    clear_stats();
    exp_tgt    = t;
    start      = 1'b1;
    load_data  = d;
    target_sel = t;
    @(posedge cfg_clk); #1;
    k          = cyc;
    start      = 1'b0;
    load_data  = 16'($urandom);
    target_sel = 1'($urandom);
  endtask

  task automatic wait_done(output bit to);
    to = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge cfg_clk); #1;
      if (done_cnt > 0) begin
        to = 1'b0;
        break;
      end
    end
    @(posedge cfg_clk); #1;
  endtask

  task automatic test_reset;
    cfg_reset_n = 1'b0;
    start       = 1'b1;
    clear_req   = 1'b0;
    load_data   = 16'hFFFF;
    target_sel  = 1'b1;
    exp_tgt     = 1'b0;
    repeat (3) @(posedge cfg_clk);
    #1;
    n_checks++;
    if ({busy, done, sr_data, sr_clk, sr_sel_div, sr_sel_row, sr_reset} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b, expected 0000000",
               {busy, done, sr_data, sr_clk, sr_sel_div, sr_sel_row, sr_reset});
    end
    start       = 1'b0;
    cfg_reset_n = 1'b1;
    @(posedge cfg_clk); #1;
  endtask

  task automatic test_loads;
    logic [W-1:0] d;
    logic         t;
    int           k;
    bit           to;
    for (int n = 0; n < 8; n++) begin
      if (n == 0) begin d = 16'hA5C3; t = 1'b0; end
      else if (n == 1) begin d = 16'h0001; t = 1'b1; end
      else begin d = 16'($urandom); t = 1'($urandom); end
      issue_start(d, t, k);
      wait_done(to);
      n_checks++;
      if (rise_cnt != W || got_word !== d) begin
        n_errors++;
        $display("FAIL load%0d_word: got %h (%0d rises), expected %h (%0d rises)",
                 n, got_word, rise_cnt, d, W);
      end
      n_checks++;
      if (to || done_cnt != 1 || done_cyc - k != LAT || first_busy != k
          || busy_cnt != LAT || rst_cnt != AC * D) begin
        n_errors++;
        $display("FAIL load%0d_timing: timeout=%0d done=%0d at +%0d busy_first=+%0d busy=%0d rst=%0d, expected done=1 at +%0d busy_first=+0 busy=%0d rst=%0d",
                 n, to, done_cnt, done_cyc - k, first_busy - k, busy_cnt, rst_cnt,
                 LAT, LAT, AC * D);
      end
      n_checks++;
      if (sel_err + stab_err + idle_err != 0) begin
        n_errors++;
        $display("FAIL load%0d_protocol: sel_err=%0d data_unstable=%0d idle_err=%0d, expected all 0",
                 n, sel_err, stab_err, idle_err);
      end
    end
  endtask

  task automatic test_clear;
    int k;
    bit to;
    clear_stats();
    clear_req = 1'b1;
    start     = 1'b1;
    load_data = 16'($urandom);
    @(posedge cfg_clk); #1;
    k         = cyc;
    clear_req = 1'b0;
    start     = 1'b0;
    wait_done(to);
    repeat (40) @(posedge cfg_clk);
    #1;
    n_checks++;
    if (to || done_cnt != 1 || done_cyc - k != D || rst_cnt != D || busy_cnt != D
        || rise_cnt != 0) begin
      n_errors++;
      $display("FAIL clear: timeout=%0d done=%0d at +%0d rst=%0d busy=%0d rises=%0d, expected done=1 at +%0d rst=%0d busy=%0d rises=0",
               to, done_cnt, done_cyc - k, rst_cnt, busy_cnt, rise_cnt, D, D, D);
    end
    n_checks++;
    if (sel_err + idle_err != 0) begin
      n_errors++;
      $display("FAIL clear_protocol: sel_err=%0d idle_err=%0d, expected 0", sel_err, idle_err);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] d1, d2;
    int           k;
    bit           to;
    d1 = 16'($urandom) & 16'h7FFE;
    issue_start(d1, 1'b0, k);
    repeat (9) @(posedge cfg_clk);
    #1;
    start = 1'b1; load_data = 16'hFFFF; target_sel = 1'b1;
    @(posedge cfg_clk); #1;
    start = 1'b0;
    wait_done(to);
    n_checks++;
    if (to || got_word !== d1 || rise_cnt != W || done_cnt != 1 || done_cyc - k != LAT
        || sel_err != 0) begin
      n_errors++;
      $display("FAIL ignore_start: timeout=%0d word=%h rises=%0d done=%0d at +%0d sel_err=%0d, expected word=%h rises=%0d done=1 at +%0d",
               to, got_word, rise_cnt, done_cnt, done_cyc - k, sel_err, d1, W, LAT);
    end
    d2 = 16'($urandom);
    issue_start(d2, 1'b1, k);
    wait_done(to);
    n_checks++;
    if (to || got_word !== d2 || rise_cnt != W || first_busy != k || done_cyc - k != LAT) begin
      n_errors++;
      $display("FAIL back_to_back: timeout=%0d word=%h rises=%0d busy_first=+%0d done=+%0d, expected word=%h rises=%0d busy_first=+0 done=+%0d",
               to, got_word, rise_cnt, first_busy - k, done_cyc - k, d2, W, LAT);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] d;
    int           k;
    bit           to;
    bit           hit;
    d = 16'($urandom);
    issue_start(d, 1'b1, k);
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge cfg_clk); #1;
      if (rise_cnt == 5) begin
        hit = 1'b1;
        break;
      end
    end
    cfg_reset_n = 1'b0;
    @(posedge cfg_clk); #1;
    n_checks++;
    if (!hit || {busy, done, sr_data, sr_clk, sr_sel_div, sr_sel_row, sr_reset} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_mid: reached_5th_high=%0d outputs=%b, expected 1 and 0000000",
               hit, {busy, done, sr_data, sr_clk, sr_sel_div, sr_sel_row, sr_reset});
    end
    cfg_reset_n = 1'b1;
    repeat (3 * LAT) @(posedge cfg_clk);
    #1;
    n_checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_abort: done pulses=%0d busy=%b, expected 0 and 0", done_cnt, busy);
    end
    d = 16'($urandom);
    issue_start(d, 1'b0, k);
    wait_done(to);
    n_checks++;
    if (to || got_word !== d || rise_cnt != W || done_cyc - k != LAT
        || sel_err + stab_err + idle_err != 0) begin
      n_errors++;
      $display("FAIL reset_recover: timeout=%0d word=%h rises=%0d done=+%0d errs=%0d, expected word=%h rises=%0d done=+%0d errs=0",
               to, got_word, rise_cnt, done_cyc - k, sel_err + stab_err + idle_err, d, W, LAT);
    end
  endtask

  initial begin
    prev_clk  = 1'b0;
    prev_data = 1'b0;
    clear_stats();
    test_reset();
    test_loads();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
